// File: rtl/room_pkg.sv
// ----------------------------------------------------------------------------
// room_pkg
// Shared constants and helpers for the room lighting controller.
//   cnt_w(n) : bits needed to hold a count of 0..n (popcount width)
//   LT_W     : width of the lit-time energy accumulator
//   LT_MAX   : saturation value of the lit-time accumulator
// No ports (package).
// ----------------------------------------------------------------------------
package room_pkg;

    localparam int LT_W = 32;
    localparam logic [LT_W-1:0] LT_MAX = {LT_W{1'b1}};

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/room_light_ctrl_if.sv
// ----------------------------------------------------------------------------
// room_light_ctrl_if
// Bundles the sensor/override inputs and lighting/status outputs of
// room_light_ctrl.
//   rooms, force_on, force_off : per-room inputs (driven by master)
//   lightson, countdown        : per-room light enables and flattened timers
//   occ_count, lit_count       : popcounts of rooms and lightson
//   all_dark                   : one-cycle pulse when the last light goes off
//   lit_time                   : lit room-tick accumulator, only present when
//                                ROOM_ENERGY_CNT_EN is defined
// Modports: master (sensor side / testbench), slave (controller).
// ----------------------------------------------------------------------------
interface room_light_ctrl_if #(
    parameter int N_ROOMS = 8,
    parameter int CW      = 4
);
    import room_pkg::*;

    localparam int C_W = cnt_w(N_ROOMS);

    logic [N_ROOMS-1:0]    rooms;
    logic [N_ROOMS-1:0]    force_on;
    logic [N_ROOMS-1:0]    force_off;
    logic [N_ROOMS-1:0]    lightson;
    logic [N_ROOMS*CW-1:0] countdown;
    logic [C_W-1:0]        occ_count;
    logic [C_W-1:0]        lit_count;
    logic                  all_dark;
`ifdef ROOM_ENERGY_CNT_EN
    logic [LT_W-1:0]       lit_time;
`endif

`ifdef ROOM_ENERGY_CNT_EN
    modport master (
        output rooms, force_on, force_off,
        input  lightson, countdown, occ_count, lit_count, all_dark, lit_time
    );
    modport slave (
        input  rooms, force_on, force_off,
        output lightson, countdown, occ_count, lit_count, all_dark, lit_time
    );
`else
    modport master (
        output rooms, force_on, force_off,
        input  lightson, countdown, occ_count, lit_count, all_dark
    );
    modport slave (
        input  rooms, force_on, force_off,
        output lightson, countdown, occ_count, lit_count, all_dark
    );
`endif

endinterface

// File: rtl/room_timer.sv
// ----------------------------------------------------------------------------
// room_timer
// One room channel: hold-off countdown with priority update
// (force_off > occupied > tick decrement > hold) and the registered light
// enable for that room.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_tick         : prescaled countdown tick
//   i_room         : occupancy sensor, 1 = occupied
//   i_force_on     : level, forces light on (timer untouched)
//   i_force_off    : level, clears timer and light
//   o_countdown    : current countdown value
//   o_light        : registered light enable
//   o_light_next   : value o_light takes at the next edge (for top-level
//                    popcount / all-dark detection aligned with o_light)
// ----------------------------------------------------------------------------
module room_timer #(
    parameter int CW   = 4,
    parameter int HOLD = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_room,
    input  logic          i_force_on,
    input  logic          i_force_off,
    output logic [CW-1:0] o_countdown,
    output logic          o_light,
    output logic          o_light_next
);

    logic [CW-1:0] r_cd;
    logic [CW-1:0] w_cd_next;
    logic          r_light;
    logic          w_light_next;

    always_comb begin
        w_cd_next = r_cd;
        if (i_force_off) begin
            w_cd_next = '0;
        end else if (i_room) begin
            w_cd_next = CW'(HOLD);
        end else if (i_tick && (r_cd != '0)) begin
            // Guarded by the non-zero test so the timer never wraps.
            w_cd_next = r_cd - 1'b1;
        end
        w_light_next = ~i_force_off & (i_force_on | (w_cd_next != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cd    <= '0;
            r_light <= 1'b0;
        end else begin
            r_cd    <= w_cd_next;
            r_light <= w_light_next;
        end
    end

    assign o_countdown  = r_cd;
    assign o_light      = r_light;
    assign o_light_next = w_light_next;

endmodule

// File: rtl/room_light_ctrl.sv
// ----------------------------------------------------------------------------
// room_light_ctrl
// Occupancy-driven lighting controller for N_ROOMS rooms. Holds the tick
// prescaler, one room_timer per room, the occupancy/lit popcounts, the
// all-dark event pulse and (optionally) the lit-time energy accumulator.
// Parameters: N_ROOMS (1..32), CW (countdown bits), HOLD (reload value),
//             TICK_DIV (clk cycles per countdown tick, >= 1).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : room_light_ctrl_if.slave (inputs rooms/force_on/force_off,
//              outputs lightson/countdown/occ_count/lit_count/all_dark
//              and lit_time)
// Optional feature macro: ROOM_ENERGY_CNT_EN adds the saturating lit_time
// accumulator (lit room-ticks); without it lit_time does not exist.
// ----------------------------------------------------------------------------
module room_light_ctrl
    import room_pkg::*;
#(
    parameter int N_ROOMS  = 8,
    parameter int CW       = 4,
    parameter int HOLD     = 10,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    room_light_ctrl_if.slave  bus
);

    localparam int C_W = cnt_w(N_ROOMS);
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic logic [C_W-1:0] popcnt(input logic [N_ROOMS-1:0] v);
        logic [C_W-1:0] s;
        s = '0;
        for (int k = 0; k < N_ROOMS; k++) begin
            s = s + C_W'(v[k]);
        end
        return s;
    endfunction

    // ---------------- prescaler ----------------
    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ---------------- per-room channels ----------------
    logic [N_ROOMS-1:0]    w_lightson;
    logic [N_ROOMS-1:0]    w_light_next;
    logic [N_ROOMS*CW-1:0] w_countdown;

    generate
        for (genvar gi = 0; gi < N_ROOMS; gi++) begin : g_room
            room_timer #(
                .CW   (CW),
                .HOLD (HOLD)
            ) u_timer (
                .clk          (clk),
                .rst          (rst),
                .i_tick       (w_tick),
                .i_room       (bus.rooms[gi]),
                .i_force_on   (bus.force_on[gi]),
                .i_force_off  (bus.force_off[gi]),
                .o_countdown  (w_countdown[gi*CW +: CW]),
                .o_light      (w_lightson[gi]),
                .o_light_next (w_light_next[gi])
            );
        end
    endgenerate

    // ---------------- status ----------------
    logic [C_W-1:0] r_occ_count;
    logic [C_W-1:0] r_lit_count;
    logic           r_all_dark;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ_count <= '0;
            r_lit_count <= '0;
            r_all_dark  <= 1'b0;
        end else begin
            r_occ_count <= popcnt(bus.rooms);
            // Counted from the next-state vector so it lines up with lightson.
            r_lit_count <= popcnt(w_light_next);
            r_all_dark  <= (|w_lightson) & ~(|w_light_next);
        end
    end

    assign bus.lightson  = w_lightson;
    assign bus.countdown = w_countdown;
    assign bus.occ_count = r_occ_count;
    assign bus.lit_count = r_lit_count;
    assign bus.all_dark  = r_all_dark;

`ifdef ROOM_ENERGY_CNT_EN
    // ---------------- energy accumulator ----------------
    logic [LT_W-1:0] r_lit_time;
    logic [LT_W:0]   w_lit_sum;

    // One extra bit catches the carry out for saturation.
    assign w_lit_sum = {1'b0, r_lit_time} + (LT_W + 1)'(popcnt(w_lightson));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lit_time <= '0;
        end else if (w_tick) begin
            r_lit_time <= w_lit_sum[LT_W] ? LT_MAX : w_lit_sum[LT_W-1:0];
        end
    end

    assign bus.lit_time = r_lit_time;
`endif

endmodule

// File: doc/room_light_ctrl.md
# room_light_ctrl

Parametrised occupancy-driven lighting controller for N rooms, successor to the fixed 8-room occupancy/countdown block. Each room has a hold-off countdown that reloads while the room is occupied and decrements on a prescaled tick once it is vacant; the light stays on while the countdown is non-zero. New in this generation:
- per-room force-on/force-off overrides
- programmable tick prescaler
- lit-room count
- all-dark event pulse
- optional energy (lit-time) accumulator

Sits between the room sensor inputs and the lighting drivers/status display.

## Interface
- N_ROOMS, 8, number of rooms/channels (1..32)
- CW, 4, countdown width in bits
- HOLD, 10, countdown reload value; 1 ≤ HOLD ≤ 2^CW−1
- TICK_DIV, 1, clk cycles per countdown tick (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- rooms  in  N_ROOMS  occupancy sensor per room, 1 = occupied
- force_on  in  N_ROOMS  level; forces light on, timer unaffected
- force_off  in  N_ROOMS  level; clears timer and light
- lightson  out  N_ROOMS  registered light enable per room
- countdown  out  N_ROOMS*CW  flattened timers, room i at [i*CW +: CW]
- occ_count  out  $clog2(N_ROOMS+1)  popcount of rooms sampled at last edge
- lit_count  out  $clog2(N_ROOMS+1)  popcount of lightson
- all_dark  out  1  one-cycle pulse when lightson goes non-zero → zero
- lit_time  out  32  lit room-ticks, saturating (only with ROOM_ENERGY_CNT_EN)

## Operation
- Reset: all outputs 0, prescaler 0, all timers 0.
- Prescaler: counts 0..TICK_DIV−1 and wraps. tick = 1 on the edge where prescaler == TICK_DIV−1. With TICK_DIV = 1, tick = 1 every cycle.
- Per-room timer update at each edge, priority high → low:
  - force_off[i]: countdown ← 0
  - rooms[i]: countdown ← HOLD
  - tick and countdown ≠ 0: countdown ← countdown − 1
  - otherwise: hold
- Countdown never wraps below 0.
- lightson[i] ← ~force_off[i] & (force_on[i] | next_countdown[i] ≠ 0). force_off beats force_on.
- occ_count ← popcount(rooms) at the same edge.
- lit_count ← popcount(next lightson), so it is always aligned with lightson.
- all_dark ← (lightson ≠ 0) & (next lightson == 0). Otherwise 0.
- Per-room state is independent; simultaneous events in different rooms need no arbitration.

## Timing
- Latency from rooms[i] rising to lightson[i]/countdown[i] updating: 1 edge.
- After the last occupied edge, the light goes off exactly HOLD ticks later, i.e. HOLD*TICK_DIV cycles at worst when tick-aligned.
- Continuous occupancy holds countdown at HOLD; it does not decrement.
- Reset asserted mid-countdown: all state cleared at that edge. First tick after release occurs TICK_DIV cycles later.
- force_on/force_off take effect on the next edge and are not latched.

## Configuration
- ROOM_ENERGY_CNT_EN defined:
  - lit_time port present.
  - On each tick edge, lit_time ← lit_time + popcount(current lightson), saturating at 32'hFFFF_FFFF.
  - Cleared by rst.
- Not defined: the lit_time port and its logic are absent; all other behaviour is identical.

## Structure
- Package room_pkg holds:
  - count-width function cnt_w(n) = $clog2(n+1)
  - lit_time width constant LT_W = 32
  - saturation max constant
- Sub-module room_timer: one channel containing the countdown register, priority update and per-room lightson. Instantiated N_ROOMS times via generate.
- Top level holds the prescaler, popcounts, all_dark and the energy accumulator.

## Test plan
- Reset check, N_ROOMS=8, CW=4, HOLD=10, TICK_DIV=1: hold rst 2 cycles → lightson=0, countdown=0, occ_count=0, lit_count=0, all_dark=0.
- rooms=8'b00010010 for one cycle then 0:
  - countdown1 = countdown4 = 10 on the next edge, then decrement 9..0.
  - lightson=8'b00010010 and lit_count=2 for 10 cycles.
  - Both bits drop together; all_dark pulses for one cycle on that edge.
- rooms=8'hFF held 20 cycles → occ_count=8, lit_count=8, all countdowns stay 10. Then rooms=0 → all lights off 10 cycles later, single all_dark pulse.
- rooms[0]=1 and force_off[0]=1 together → countdown0=0, lightson[0]=0. Add force_on[0]=1 → still off. Release force_off → light on, countdown0=10.
- TICK_DIV=4, pulse rooms[0] once → countdown0 steps down every 4 cycles; light off after 40 cycles ±3 depending on tick alignment. Assert rst at countdown0=5 → all zeros on the next edge.
- With ROOM_ENERGY_CNT_EN, TICK_DIV=1, rooms=8'b00000011 for one cycle → lit_time = 20 after the lights go off. Preload near max (force-sim) → lit_time saturates at 32'hFFFF_FFFF.
